sram_arbiter: RTL and testbench
===============================

# sram_arbiter

Two-requester round-robin arbiter that shares one `sram_23lc1024` controller between independent clients, e.g. a UART loader and a display or readback engine. It sits between the clients and the SRAM controller's `wr_en`/`rd_en`/`address_in`/`data_in`/`data_out`/`completed` interface. It serialises single-byte read/write transactions and returns one `ack` pulse per transaction to the owning client.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, default 4096: `clk` cycles allowed in WAIT before abort (only used with `SRAM_ARB_TIMEOUT_EN`; minimum 2).

Ports:
- `clk`  in  1  system clock; all logic on its rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `a_req`, `b_req`  in  1  transaction request; held high until own `ack`.
- `a_we`, `b_we`  in  1  1 = write, 0 = read; stable while req high.
- `a_addr`, `b_addr`  in  24  byte address; stable while req high.
- `a_wdata`, `b_wdata`  in  8  write data; stable while req high.
- `a_ack`, `b_ack`  out  1  one-cycle completion pulse.
- `a_rdata`, `b_rdata`  out  8  read data; valid from ack cycle, held until that port's next ack.
- `a_err`, `b_err`  out  1  valid with ack; 1 = transaction aborted by timeout.
- `sram_wr_en`, `sram_rd_en`  out  1  one-cycle start strobes to the controller.
- `sram_address`  out  24  latched address.
- `sram_data_in`  out  8  latched write data.
- `sram_data_out`  in  8  controller read data.
- `sram_completed`  in  1  controller done pulse.

## Operation
- States: IDLE, WAIT, DONE.
- IDLE: if any req is high, pick a winner.
  - Only one req high: that port wins.
  - Both high: the port not in `last_grant` wins.
  - Set `owner` and `last_grant` to the winner. Latch its `addr`/`wdata`/`we` into `sram_address`/`sram_data_in`. Assert `sram_wr_en` (we=1) or `sram_rd_en` (we=0) for exactly one cycle. Go to WAIT.
- WAIT:
  - On `sram_completed`: if the operation was a read, capture `sram_data_out` into the owner's rdata. Go to DONE.
  - Otherwise remain in WAIT.
- DONE: assert the owner's ack for one cycle (err per timeout rule), then go to IDLE. This state gives the client one cycle to drop req, so no duplicate issue occurs.
- `sram_completed` outside WAIT is ignored.
- A req that drops before grant is simply not served. Dropping req after grant does not abort the transaction.
- Write data is never returned; rdata is unchanged on writes.

Reset (async, `rst_n`=0):
- State IDLE; `last_grant`=B, so A wins the first tie.
- All acks, errs, and SRAM strobes 0.
- `sram_address`=0, `sram_data_in`=0, both rdata=0.
- Timeout counter 0.
- Reset mid-transaction drops the transaction silently; no ack is issued.

## Timing
- Request first sampled high at edge N: strobe high in cycle N..N+1; state WAIT from edge N+1.
- `sram_completed` sampled at edge M: ack high in cycle M..M+1. Earliest next grant is at edge M+2.
- Arbiter overhead: 2 cycles plus the controller's own latency.
- Back-to-back with both clients always requesting: strict A/B alternation.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Configuration
- `SRAM_ARB_TIMEOUT_EN` defined:
  - A 16-bit counter clears on entry to WAIT and increments each WAIT cycle.
  - Reaching `TIMEOUT_CYCLES` without `sram_completed` → DONE with the owner's err=1 and rdata=0x00.
  - If `sram_completed` arrives in the same cycle as expiry, completion wins and err=0.
- Undefined: no counter logic is synthesised, errs are tied 0, and WAIT persists until `sram_completed`.

## Test plan
- A write: `a_req`=1, `a_we`=1, `a_addr`=0x000012, `a_wdata`=0xA5 → `sram_wr_en` pulses once with address 0x000012 and data 0xA5. Completion 10 cycles later → `a_ack` pulse 1 cycle later, `a_err`=0.
- B read: `b_addr`=0x01FFFF, controller returns 0x3C → `b_ack` pulse, `b_rdata`=0x3C held until the next B ack; `a_rdata` unchanged.
- Tie after reset: both req high with fixed 5-cycle completion → grant sequence A, B, A, B; exactly one strobe per grant; never two transactions in flight.
- Reset mid-operation: assert `rst_n`=0 during WAIT → all outputs 0 immediately. After release, no stale ack, and the next tie is granted to A.
- Spurious `sram_completed` while in IDLE → no ack and no state change.
- With `SRAM_ARB_TIMEOUT_EN` and `TIMEOUT_CYCLES`=8, completion withheld → ack with err=1 and rdata=0x00, 10 cycles after the grant edge. Completion arriving exactly at expiry → err=0. Without the macro → no ack until completion.

Source files
------------

// File: rtl/sram_arbiter.sv
`timescale 1ns/1ps
// sram_arbiter
//   Two-client round-robin arbiter in front of a single sram_23lc1024
//   controller. Serialises single-byte read/write transactions and returns
//   one ack pulse per transaction to the client that owned it.
//
//   Ports
//     clk, rst_n                      clock, async active-low reset
//     a_req/b_req                     request, held high until own ack
//     a_we/b_we, a_addr/b_addr,       transaction attributes, stable while
//     a_wdata/b_wdata                 req is high
//     a_ack/b_ack                     one-cycle completion pulse
//     a_rdata/b_rdata                 read data, held until next own ack
//     a_err/b_err                     valid with ack, 1 = aborted by timeout
//     sram_wr_en/sram_rd_en           one-cycle start strobes
//     sram_address/sram_data_in       latched transaction address/data
//     sram_data_out/sram_completed    controller read data / done pulse
//
//   Optional feature: define SRAM_ARB_TIMEOUT_EN to abort a transaction when
//   the controller has not completed within TIMEOUT_CYCLES cycles of WAIT.
//   Without it, errs are constant 0 and WAIT lasts until sram_completed.
module sram_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 4096
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        a_req,
  input  logic        a_we,
  input  logic [23:0] a_addr,
  input  logic [7:0]  a_wdata,
  output logic        a_ack,
  output logic [7:0]  a_rdata,
  output logic        a_err,
  input  logic        b_req,
  input  logic        b_we,
  input  logic [23:0] b_addr,
  input  logic [7:0]  b_wdata,
  output logic        b_ack,
  output logic [7:0]  b_rdata,
  output logic        b_err,
  output logic        sram_wr_en,
  output logic        sram_rd_en,
  output logic [23:0] sram_address,
  output logic [7:0]  sram_data_in,
  input  logic [7:0]  sram_data_out,
  input  logic        sram_completed
);

  // The counter is 16 bits wide; TIMEOUT_CYCLES must fit and be at least 2.
  if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65535) begin : g_param_chk
    $error("sram_arbiter: TIMEOUT_CYCLES out of range");
  end

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

  state_t      r_state, w_state_nxt;
  logic        r_owner;       // 0 = A, 1 = B
  logic        r_last_grant;  // 0 = A, 1 = B
  logic        r_we;
  logic [23:0] r_addr;
  logic [7:0]  r_wdata;
  logic        r_wr_en, r_rd_en;
  logic        r_a_ack, r_b_ack, r_a_err, r_b_err;
  logic [7:0]  r_a_rdata, r_b_rdata;

  logic w_grant, w_winner, w_expired, w_finish;

  assign w_grant  = (r_state == S_IDLE) & (a_req | b_req);
  // A tie goes to the port that was not served last.
  assign w_winner = (a_req & b_req) ? ~r_last_grant : b_req;

`ifdef SRAM_ARB_TIMEOUT_EN
  logic [15:0] r_cnt;

  // Held at 0 outside WAIT, so it starts from 0 on every entry to WAIT.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                r_cnt <= '0;
    else if (r_state == S_WAIT) r_cnt <= r_cnt + 16'd1;
    else                       r_cnt <= '0;
  end

  // Completion in the expiry cycle takes priority over the abort.
  assign w_expired = (r_state == S_WAIT) & ~sram_completed &
                     (r_cnt == 16'(TIMEOUT_CYCLES));
`else
  assign w_expired = 1'b0;
`endif

  assign w_finish = (r_state == S_WAIT) & (sram_completed | w_expired);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE:  if (w_grant)  w_state_nxt = S_WAIT;
      S_WAIT:  if (w_finish) w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Datapath: strobes and acks are single-cycle pulses; ack is registered on
  // the WAIT->DONE edge so it is high for exactly the DONE cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_owner      <= 1'b0;
      r_last_grant <= 1'b1;
      r_we         <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_wr_en      <= 1'b0;
      r_rd_en      <= 1'b0;
      r_a_ack      <= 1'b0;
      r_b_ack      <= 1'b0;
      r_a_err      <= 1'b0;
      r_b_err      <= 1'b0;
      r_a_rdata    <= '0;
      r_b_rdata    <= '0;
    end else begin
      r_wr_en <= 1'b0;
      r_rd_en <= 1'b0;
      r_a_ack <= 1'b0;
      r_b_ack <= 1'b0;
      r_a_err <= 1'b0;
      r_b_err <= 1'b0;
      if (w_grant) begin
        r_owner      <= w_winner;
        r_last_grant <= w_winner;
        r_we         <= w_winner ? b_we    : a_we;
        r_addr       <= w_winner ? b_addr  : a_addr;
        r_wdata      <= w_winner ? b_wdata : a_wdata;
        r_wr_en      <= w_winner ? b_we    : a_we;
        r_rd_en      <= w_winner ? ~b_we   : ~a_we;
      end
      if (w_finish) begin
        r_a_ack <= ~r_owner;
        r_b_ack <=  r_owner;
        r_a_err <= ~r_owner & w_expired;
        r_b_err <=  r_owner & w_expired;
        if (w_expired) begin
          if (r_owner) r_b_rdata <= '0;
          else         r_a_rdata <= '0;
        end else if (!r_we) begin
          if (r_owner) r_b_rdata <= sram_data_out;
          else         r_a_rdata <= sram_data_out;
        end
      end
    end
  end

  assign a_ack        = r_a_ack;
  assign b_ack        = r_b_ack;
  assign a_err        = r_a_err;
  assign b_err        = r_b_err;
  assign a_rdata      = r_a_rdata;
  assign b_rdata      = r_b_rdata;
  assign sram_wr_en   = r_wr_en;
  assign sram_rd_en   = r_rd_en;
  assign sram_address = r_addr;
  assign sram_data_in = r_wdata;

endmodule

// File: tb/tb_sram_arbiter.sv
`timescale 1ns/1ps
// Bench for sram_arbiter: a transaction-level model of the arbiter plus a
// behavioural SRAM controller; every output is compared each cycle, with a
// few directed scenarios pinned to hand-computed values.
module tb_sram_arbiter;
  localparam int TO = 8;

  logic        clk = 1'b0, rst_n = 1'b0;
  logic        a_req = 1'b0, b_req = 1'b0, a_we = 1'b0, b_we = 1'b0;
  logic [23:0] a_addr = '0, b_addr = '0;
  logic [7:0]  a_wdata = '0, b_wdata = '0;
  logic        a_ack, b_ack, a_err, b_err, sram_wr_en, sram_rd_en;
  logic [7:0]  a_rdata, b_rdata, sram_data_in;
  logic [23:0] sram_address;
  logic [7:0]  sram_data_out = '0;
  logic        sram_completed = 1'b0;

  always #5 clk = ~clk;

  sram_arbiter #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_ack(a_ack), .a_rdata(a_rdata), .a_err(a_err),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_ack(b_ack), .b_rdata(b_rdata), .b_err(b_err),
    .sram_wr_en(sram_wr_en), .sram_rd_en(sram_rd_en),
    .sram_address(sram_address), .sram_data_in(sram_data_in),
    .sram_data_out(sram_data_out), .sram_completed(sram_completed)
  );

  int n_chk = 0, n_err = 0, cyc = 0, n_strobe = 0;

  // Transaction-level model: is a transaction outstanding, who owns it, how
  // many waiting cycles have elapsed, and is this the ack cycle.
  bit          m_busy, m_ackcyc, m_owner, m_last, m_we;
  int          m_wait;
  bit          e_wr, e_rd, e_aack, e_back, e_aerr, e_berr;
  logic [23:0] e_addr;
  logic [7:0]  e_wdata, e_ard, e_brd;

  // Controller model knobs.
  int   ctl_cnt = 0, ctl_lat = 5;
  bit   ctl_hold = 0, ctl_spur = 0, ctl_rand = 0;
  logic [7:0] ctl_data = '0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", nm, cyc, act, exp);
    end
  endtask

  task automatic model_reset();
    m_busy = 0; m_ackcyc = 0; m_owner = 0; m_last = 1; m_we = 0; m_wait = 0;
    e_wr = 0; e_rd = 0; e_aack = 0; e_back = 0; e_aerr = 0; e_berr = 0;
    e_addr = '0; e_wdata = '0; e_ard = '0; e_brd = '0;
  endtask

  // Advance the model by the clock edge just passed, using the inputs that
  // were presented to that edge.
  task automatic model_step();
    bit to;
    if (!rst_n) begin model_reset(); return; end
    e_wr = 0; e_rd = 0; e_aack = 0; e_back = 0; e_aerr = 0; e_berr = 0;
    if (m_ackcyc) m_ackcyc = 0;              // client gets one cycle to drop req
    else if (!m_busy) begin
      if (a_req || b_req) begin
        m_owner = (a_req && b_req) ? !m_last : b_req;
        m_last  = m_owner;
        m_busy  = 1;
        m_wait  = 0;
        m_we    = m_owner ? b_we : a_we;
        e_addr  = m_owner ? b_addr : a_addr;
        e_wdata = m_owner ? b_wdata : a_wdata;
        e_wr    = m_we;
        e_rd    = !m_we;
      end
    end else begin
      to = 0;
`ifdef SRAM_ARB_TIMEOUT_EN
      to = !sram_completed && (m_wait == TO);
`endif
      if (sram_completed || to) begin
        m_busy = 0; m_ackcyc = 1;
        if (m_owner) begin
          e_back = 1; e_berr = to;
          if (to) e_brd = 8'h00; else if (!m_we) e_brd = sram_data_out;
        end else begin
          e_aack = 1; e_aerr = to;
          if (to) e_ard = 8'h00; else if (!m_we) e_ard = sram_data_out;
        end
      end else m_wait++;
    end
  endtask

  task automatic compare();
    chk("sram_wr_en", sram_wr_en, e_wr);
    chk("sram_rd_en", sram_rd_en, e_rd);
    chk("sram_address", sram_address, e_addr);
    chk("sram_data_in", sram_data_in, e_wdata);
    chk("a_ack", a_ack, e_aack);
    chk("b_ack", b_ack, e_back);
    chk("a_err", a_err, e_aerr);
    chk("b_err", b_err, e_berr);
    chk("a_rdata", a_rdata, e_ard);
    chk("b_rdata", b_rdata, e_brd);
  endtask

  // Controller: completes L cycles after seeing a strobe, optionally with
  // spurious completion pulses while nothing is outstanding.
  task automatic ctl_step();
    sram_completed = 1'b0;
    if (!rst_n) begin ctl_cnt = 0; return; end
    if (ctl_cnt > 0) begin
      ctl_cnt--;
      if (ctl_cnt == 0) begin
        sram_completed = 1'b1;
        sram_data_out  = ctl_rand ? 8'($urandom) : ctl_data;
      end
    end
    if ((e_wr || e_rd) && !ctl_hold)
      ctl_cnt = (ctl_lat > 0) ? ctl_lat : int'($urandom_range(6, 1));
    else if (ctl_spur && !m_busy && ctl_cnt == 0 && $urandom_range(7, 0) == 0)
      sram_completed = 1'b1;
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    cyc++;
    model_step();
    compare();
    n_strobe += int'(sram_wr_en) + int'(sram_rd_en);
    ctl_step();
  endtask

  task automatic wait_ack(output int port, output int at);
    int k = 0;
    port = -1;
    while (k < 200 && port < 0) begin
      tick(); k++;
      if (a_ack) port = 0; else if (b_ack) port = 1;
    end
    if (port < 0) begin
      n_chk++; n_err++;
      $display("FAIL ack_wait: no ack within 200 cycles, required one");
    end
    at = cyc;
  endtask

  initial begin
    int s, p, at, base;
    int seq[4];
    model_reset();
    repeat (3) tick();
    chk("rst_strobes", {sram_wr_en, sram_rd_en}, 2'b00);
    chk("rst_addr", sram_address, 24'h0);
    chk("rst_acks", {a_ack, b_ack}, 2'b00);
    rst_n = 1'b1;
    tick();

    // A write, completion 10 cycles after the strobe.
    a_req = 1; a_we = 1; a_addr = 24'h000012; a_wdata = 8'hA5; ctl_lat = 10;
    tick(); s = cyc;
    chk("t1_wr_en", sram_wr_en, 1'b1);
    chk("t1_addr", sram_address, 24'h000012);
    chk("t1_data", sram_data_in, 8'hA5);
    tick();
    chk("t1_one_strobe", sram_wr_en, 1'b0);
    wait_ack(p, at); a_req = 0;
    chk("t1_port", p, 0);
    chk("t1_ack_cycle", at - s, 11);
    chk("t1_err", a_err, 1'b0);
    repeat (2) tick();

    // B read returning 0x3C.
    b_req = 1; b_we = 0; b_addr = 24'h01FFFF; ctl_lat = 3; ctl_data = 8'h3C;
    tick();
    chk("t2_rd_en", sram_rd_en, 1'b1);
    chk("t2_addr", sram_address, 24'h01FFFF);
    wait_ack(p, at); b_req = 0;
    chk("t2_port", p, 1);
    chk("t2_b_rdata", b_rdata, 8'h3C);
    chk("t2_a_rdata", a_rdata, 8'h00);
    tick();
    a_req = 1; a_we = 0; a_addr = 24'h000400; ctl_data = 8'h77;
    wait_ack(p, at); a_req = 0;
    chk("t2_a_read", a_rdata, 8'h77);
    chk("t2_b_held", b_rdata, 8'h3C);
    repeat (2) tick();

    // Spurious completion while idle.
    sram_completed = 1'b1;
    repeat (3) tick();
    chk("t3_no_ack", {a_ack, b_ack}, 2'b00);
    chk("t3_no_strobe", {sram_wr_en, sram_rd_en}, 2'b00);

    // Tie after reset: A, B, A, B with exactly one strobe per grant.
    rst_n = 0; tick(); rst_n = 1; tick();
    ctl_lat = 5; base = n_strobe;
    a_req = 1; a_we = 1'($urandom); a_addr = 24'($urandom); a_wdata = 8'($urandom);
    b_req = 1; b_we = 1'($urandom); b_addr = 24'($urandom); b_wdata = 8'($urandom);
    for (int k = 0; k < 4; k++) begin
      wait_ack(p, at);
      seq[k] = p;
      chk("t4_strobes", n_strobe - base, k + 1);
      if (p == 0) a_req = 0; else b_req = 0;
      tick();
      if (p == 0) begin a_req = 1; a_addr = 24'($urandom); end
      else        begin b_req = 1; b_addr = 24'($urandom); end
    end
    chk("t4_g0", seq[0], 0); chk("t4_g1", seq[1], 1);
    chk("t4_g2", seq[2], 0); chk("t4_g3", seq[3], 1);
    a_req = 0; b_req = 0;
    repeat (12) tick();

    // Reset in WAIT: outputs clear at once, no stale ack, A wins next tie.
    a_req = 1; a_we = 0; ctl_lat = 10;
    repeat (3) tick();
    rst_n = 0;
    #1;
    chk("t5_acks", {a_ack, b_ack}, 2'b00);
    chk("t5_strobes", {sram_wr_en, sram_rd_en}, 2'b00);
    chk("t5_addr", sram_address, 24'h0);
    chk("t5_rdata", {a_rdata, b_rdata}, 16'h0);
    a_req = 0;
    tick(); rst_n = 1;
    repeat (12) tick();
    a_req = 1; b_req = 1;
    wait_ack(p, at);
    chk("t5_tie_a", p, 0);
    a_req = 0; b_req = 0;
    repeat (12) tick();

`ifdef SRAM_ARB_TIMEOUT_EN
    // Completion withheld: abort with err and rdata cleared.
    a_req = 1; a_we = 0; ctl_lat = 3; ctl_data = 8'h99;
    wait_ack(p, at); a_req = 0; tick();
    chk("t6_pre", a_rdata, 8'h99);
    ctl_hold = 1; a_req = 1;
    tick(); s = cyc;
    wait_ack(p, at); a_req = 0;
    chk("t6_to_cycle", at + 1 - s, 10);
    chk("t6_err", a_err, 1'b1);
    chk("t6_rdata", a_rdata, 8'h00);
    ctl_hold = 0; tick();
    // Completion on the expiry edge: completion wins.
    ctl_lat = 8; ctl_data = 8'h5A; a_req = 1;
    tick(); s = cyc;
    wait_ack(p, at); a_req = 0;
    chk("t7_cycle", at - s, 9);
    chk("t7_err", a_err, 1'b0);
    chk("t7_rdata", a_rdata, 8'h5A);
    tick();
`else
    // Completion withheld: WAIT persists until the controller answers.
    ctl_hold = 1; a_req = 1; a_we = 0;
    base = 0;
    repeat (30) begin tick(); base += int'(a_ack) + int'(b_ack); end
    chk("t6_no_ack", base, 0);
    sram_completed = 1'b1; sram_data_out = 8'h5A;
    wait_ack(p, at); a_req = 0;
    chk("t6_late_ack", p, 0);
    chk("t6_rdata", a_rdata, 8'h5A);
    chk("t6_err", a_err, 1'b0);
    ctl_hold = 0; tick();
`endif

    // Randomised traffic with random latency and spurious completions.
    ctl_lat = 0; ctl_spur = 1; ctl_rand = 1;
    for (int i = 0; i < 3000; i++) begin
      tick();
      if (e_aack) a_req = 0;
      else if (!a_req && $urandom_range(3, 0) == 0) begin
        a_req = 1; a_we = 1'($urandom); a_addr = 24'($urandom); a_wdata = 8'($urandom);
      end else if (a_req && !(m_busy && !m_owner) && $urandom_range(15, 0) == 0) a_req = 0;
      if (e_back) b_req = 0;
      else if (!b_req && $urandom_range(3, 0) == 0) begin
        b_req = 1; b_we = 1'($urandom); b_addr = 24'($urandom); b_wdata = 8'($urandom);
      end else if (b_req && !(m_busy && m_owner) && $urandom_range(15, 0) == 0) b_req = 0;
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
